// File: rtl/rs_queue_if.sv
// Shared packet types and the alloc/wakeup/execute-facing bundle of the reservation station.
package rs_queue_pkg;
  typedef logic [5:0] t_prf_id;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic [7:0] uinstr;
    t_prf_id    psrc1;
    t_prf_id    psrc2;
    logic       psrc1_pend;
    logic       psrc2_pend;
    t_prf_id    pdst;
    logic [4:0] robid;
    logic [3:0] meta;
  } t_disp_pkt;
endpackage

interface rs_queue_if;
  rs_queue_pkg::t_nuke_pkt nuke_rb1;
  logic                    disp_valid_rs0;
  rs_queue_pkg::t_disp_pkt disp_pkt_rs0;
  logic                    rs_stall_rs0;
  logic                    wb_valid_ex0;
  rs_queue_pkg::t_prf_id   wb_pdst_ex0;
  logic                    ex_ready_rs1;
  logic                    issue_valid_rs1;
  rs_queue_pkg::t_disp_pkt issue_pkt_rs1;

  modport master (
    output nuke_rb1, disp_valid_rs0, disp_pkt_rs0, wb_valid_ex0, wb_pdst_ex0, ex_ready_rs1,
    input  rs_stall_rs0, issue_valid_rs1, issue_pkt_rs1
  );

  modport slave (
    input  nuke_rb1, disp_valid_rs0, disp_pkt_rs0, wb_valid_ex0, wb_pdst_ex0, ex_ready_rs1,
    output rs_stall_rs0, issue_valid_rs1, issue_pkt_rs1
  );
endinterface

// File: rtl/rs_queue.sv
// Reservation station: holds dispatched uops until sources wake up, issues the oldest
// ready one per cycle into a single registered stage toward execute.
module rs_queue
  import rs_queue_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned RESERVE     = 2
) (
  input logic       clk,
  input logic       reset,
  rs_queue_if.slave rs
);
  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] src1_pend_q, src1_pend_d;
  logic [NUM_ENTRIES-1:0] src2_pend_q, src2_pend_d;
  // age_q[i][j] set means entry j is older than entry i
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];
  t_disp_pkt              pkt_q [NUM_ENTRIES];
  logic [CntW-1:0]        free_cnt_q, free_cnt_d;
  logic                   issue_valid_q;
  t_disp_pkt              issue_pkt_q, sel_pkt;

  logic [NUM_ENTRIES-1:0] ready, sel_oh, issue_oh, alloc_oh;
  logic [IdxW-1:0]        sel_idx, alloc_idx;
  logic                   any_ready, any_free, load_en, do_issue, do_alloc;
  logic                   alloc_p1, alloc_p2;

  always_comb begin
    ready     = valid_q & ~src1_pend_q & ~src2_pend_q;
    any_ready = |ready;
    sel_oh    = '0;
    sel_idx   = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      sel_oh[i] = ready[i] & ~|(age_q[i] & ready);
      if (sel_oh[i]) sel_idx = IdxW'(i);
    end
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_idx = IdxW'(i);
        any_free  = 1'b1;
      end
    end
    alloc_oh = any_free ? (NUM_ENTRIES'(1) << alloc_idx) : '0;
    load_en  = ~issue_valid_q | rs.ex_ready_rs1;
    do_issue = load_en & any_ready;
    do_alloc = rs.disp_valid_rs0 & any_free;
    issue_oh = do_issue ? sel_oh : '0;

    sel_pkt            = pkt_q[sel_idx];
    sel_pkt.psrc1_pend = 1'b0;
    sel_pkt.psrc2_pend = 1'b0;

    alloc_p1 = rs.disp_pkt_rs0.psrc1_pend &
               ~(rs.wb_valid_ex0 & (rs.wb_pdst_ex0 == rs.disp_pkt_rs0.psrc1));
    alloc_p2 = rs.disp_pkt_rs0.psrc2_pend &
               ~(rs.wb_valid_ex0 & (rs.wb_pdst_ex0 == rs.disp_pkt_rs0.psrc2));
  end

  always_comb begin
    valid_d = (valid_q & ~issue_oh) | (do_alloc ? alloc_oh : '0);
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      src1_pend_d[i] = src1_pend_q[i] &
                       ~(rs.wb_valid_ex0 & (pkt_q[i].psrc1 == rs.wb_pdst_ex0));
      src2_pend_d[i] = src2_pend_q[i] &
                       ~(rs.wb_valid_ex0 & (pkt_q[i].psrc2 == rs.wb_pdst_ex0));
      age_d[i]       = age_q[i] & ~issue_oh;
      if (do_alloc && alloc_oh[i]) begin
        src1_pend_d[i] = alloc_p1;
        src2_pend_d[i] = alloc_p2;
        age_d[i]       = valid_q & ~issue_oh;
      end
    end
    free_cnt_d = free_cnt_q + CntW'(do_issue) - CntW'(do_alloc);
  end

  always_ff @(posedge clk) begin
    if (reset || rs.nuke_rb1.valid) begin
      valid_q       <= '0;
      src1_pend_q   <= '0;
      src2_pend_q   <= '0;
      free_cnt_q    <= CntW'(NUM_ENTRIES);
      issue_valid_q <= 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) age_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      src1_pend_q <= src1_pend_d;
      src2_pend_q <= src2_pend_d;
      free_cnt_q  <= free_cnt_d;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) age_q[i] <= age_d[i];
      if (do_issue) begin
        issue_valid_q <= 1'b1;
      end else if (rs.ex_ready_rs1) begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by valid_q alone.
  always_ff @(posedge clk) begin
    if (do_alloc) pkt_q[alloc_idx] <= rs.disp_pkt_rs0;
    if (do_issue) issue_pkt_q <= sel_pkt;
  end

  assign rs.rs_stall_rs0    = (free_cnt_q <= CntW'(RESERVE));
  assign rs.issue_valid_rs1 = issue_valid_q;
  assign rs.issue_pkt_rs1   = issue_pkt_q;

  a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (reset || rs.nuke_rb1.valid)
    rs.disp_valid_rs0 |-> any_free);
  a_free_cnt_range: assert property (@(posedge clk) disable iff (reset)
    free_cnt_q <= CntW'(NUM_ENTRIES));
  a_free_cnt_under: assert property (@(posedge clk) disable iff (reset || rs.nuke_rb1.valid)
    (do_alloc && !do_issue) |-> (free_cnt_q != '0));
  a_free_cnt_over: assert property (@(posedge clk) disable iff (reset || rs.nuke_rb1.valid)
    (do_issue && !do_alloc) |-> (free_cnt_q != CntW'(NUM_ENTRIES)));
endmodule
